// File: rtl/apb4_completer_bridge_if.sv
// APB3/APB4 requester-to-completer bus bundle used by apb4_completer_bridge.
// The master modport is the APB requester, the slave modport the completer.
interface apb4_completer_bridge_if #(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 32
);
  logic [AddressWidth-1:0]  paddr;
  logic                     psel;
  logic                     penable;
  logic                     pwrite;
  logic [DataWidth-1:0]     pwdata;
  logic [DataWidth/8-1:0]   pstrb;
  logic [2:0]               pprot;
  logic                     pready;
  logic [DataWidth-1:0]     prdata;
  logic                     pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb4_completer_bridge.sv
// APB4 completer that decodes an address window and forwards each accepted
// transfer to a backend over a valid/ready request and a valid-only response.
//
//   state | meaning
//   IDLE  | waiting for a setup phase; decodes window, alignment and no-op writes
//   REQ   | req_valid high, request fields held until req_ready
//   WAIT  | request accepted, waiting for the rsp_valid pulse
//   DONE  | pready high with captured data/error until the access phase ends
//
// The timeout counter clears on entry to REQ and counts REQ/WAIT cycles; when it
// reaches TimeoutCycles without a handshake the transfer ends with an error and
// the backend request is abandoned. APB-facing outputs decode registered state
// only, so no combinational path exists from APB inputs to pready/prdata/pslverr.
module apb4_completer_bridge #(
  parameter int          AddressWidth  = 20,
  parameter int          DataWidth     = 32,
  parameter int unsigned BaseAddress   = 0,
  parameter int unsigned WindowSize    = 'h1000,
  parameter int unsigned TimeoutCycles = 256
) (
  input  logic                      pclk,
  input  logic                      presetn,
  apb4_completer_bridge_if.slave    apb,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic                      req_write,
  output logic [2:0]                req_prot,
  output logic [AddressWidth-1:0]   req_addr,
  output logic [DataWidth-1:0]      req_wdata,
  output logic [DataWidth/8-1:0]    req_strb,
  input  logic                      rsp_valid,
  input  logic [DataWidth-1:0]      rsp_rdata,
  input  logic                      rsp_error
);

  localparam int          StrbWidth = DataWidth / 8;
  // One spare count above TimeoutCycles so a late REQ handshake cannot wrap it.
  localparam int          CntWidth  = $clog2(TimeoutCycles + 2);
  localparam logic [63:0] WinLo     = 64'(BaseAddress);
  localparam logic [63:0] WinSpan   = 64'(WindowSize);
  localparam logic [63:0] AlignMask = 64'(StrbWidth - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [AddressWidth-1:0] addr_q;
  logic                    write_q;
  logic [DataWidth-1:0]    wdata_q;
  logic [StrbWidth-1:0]    strb_q;
  logic [2:0]              prot_q;
  logic [DataWidth-1:0]    rdata_q;
  logic                    err_q;
  logic [CntWidth-1:0]     cnt_q;

  logic [63:0]             offset;
  logic                    setup;
  logic                    bad_addr;
  logic                    noop_write;
  logic                    timeout_hit;

  // Offset wraps to a huge value below BaseAddress, so one compare covers both ends.
  assign offset      = 64'(apb.paddr) - WinLo;
  assign setup       = apb.psel & ~apb.penable;
  assign bad_addr    = (offset >= WinSpan) || ((offset & AlignMask) != 64'd0);
  assign noop_write  = apb.pwrite && (apb.pstrb == '0);
  assign timeout_hit = (TimeoutCycles != 0) && (cnt_q >= CntWidth'(TimeoutCycles));

  // State register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; a handshake in the timeout cycle takes priority.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (setup) begin
          if (bad_addr || noop_write) begin
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (req_ready) begin
          state_d = WAIT;
        end else if (timeout_hit) begin
          state_d = DONE;
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (apb.psel && apb.penable) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transfer capture, response capture and timeout counting.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      prot_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (setup) begin
            addr_q  <= offset[AddressWidth-1:0];
            write_q <= apb.pwrite;
            wdata_q <= apb.pwdata;
            strb_q  <= apb.pwrite ? apb.pstrb : {StrbWidth{1'b1}};
            prot_q  <= apb.pprot;
            rdata_q <= '0;
            err_q   <= bad_addr;
            cnt_q   <= '0;
          end
        end
        REQ: begin
          if (cnt_q != {CntWidth{1'b1}}) begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
          if (!req_ready && timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        WAIT: begin
          if (cnt_q != {CntWidth{1'b1}}) begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
          if (rsp_valid) begin
            rdata_q <= write_q ? '0 : rsp_rdata;
            err_q   <= rsp_error;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign req_valid = (state_q == REQ);
  assign req_write = write_q;
  assign req_prot  = prot_q;
  assign req_addr  = addr_q;
  assign req_wdata = wdata_q;
  assign req_strb  = strb_q;

  assign apb.pready  = (state_q == DONE);
  assign apb.prdata  = ((state_q == DONE) && !write_q) ? rdata_q : '0;
  assign apb.pslverr = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_apb4_completer_bridge.sv
// Bench for apb4_completer_bridge: directed scenarios plus randomized transfers
// checked against a transfer-level timing/result model.
module tb_apb4_completer_bridge;

  localparam int          AW   = 20;
  localparam int          DW   = 32;
  localparam int          SW   = DW / 8;
  localparam int unsigned BASE = 32'h2000;
  localparam int unsigned WIN  = 32'h1000;
  localparam int          TO   = 8;

  logic           pclk;
  logic           presetn;
  logic           req_valid, req_ready, req_write;
  logic [2:0]     req_prot;
  logic [AW-1:0]  req_addr;
  logic [DW-1:0]  req_wdata;
  logic [SW-1:0]  req_strb;
  logic           rsp_valid, rsp_error;
  logic [DW-1:0]  rsp_rdata;

  int total = 0;
  int bad   = 0;

  apb4_completer_bridge_if #(.AddressWidth(AW), .DataWidth(DW)) bus ();

  apb4_completer_bridge #(
    .AddressWidth(AW), .DataWidth(DW), .BaseAddress(BASE),
    .WindowSize(WIN), .TimeoutCycles(TO)
  ) dut (
    .pclk(pclk), .presetn(presetn), .apb(bus),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_prot(req_prot), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_strb(req_strb), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transfer-level model: outcome and access-phase length from the decode and
  // backend delays (req_ready after rdly REQ cycles, rsp sdly cycles after accept).
  function automatic void predict(input logic [AW-1:0] addr, input logic wr, input logic [SW-1:0] strb,
                                  input int rdly, input int sdly, input logic [DW-1:0] rdata, input logic rerr,
                                  output int e_acc, output logic [DW-1:0] e_rd, output logic e_er,
                                  output int e_reqn);
    longint off;
    int a_cyc, r_cyc, lim;
    off = longint'(addr) - longint'(BASE);
    e_rd = '0; e_er = 1'b0; e_reqn = 0;
    if (off < 0 || off >= longint'(WIN) || (off % SW) != 0) begin
      e_acc = 1; e_er = 1'b1;
    end else if (wr && strb == '0) begin
      e_acc = 1;
    end else begin
      a_cyc = rdly + 1;
      if (a_cyc > TO + 1) begin
        e_reqn = TO + 1; e_acc = TO + 2; e_er = 1'b1;
      end else begin
        e_reqn = a_cyc;
        r_cyc  = a_cyc + 1 + sdly;
        lim    = (a_cyc + 1 > TO + 1) ? a_cyc + 1 : TO + 1;
        if (r_cyc <= lim) begin
          e_acc = r_cyc + 1; e_er = rerr; e_rd = wr ? '0 : rdata;
        end else begin
          e_acc = lim + 1; e_er = 1'b1;
        end
      end
    end
  endfunction

  // Runs one APB transfer while acting as the backend; counts request-field
  // instability in fbad. acc = access cycles up to and including pready (-1 on budget).
  task automatic xfer(input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wdata,
                      input logic [SW-1:0] strb, input logic [2:0] prot, input int rdly, input int sdly,
                      input logic [DW-1:0] rdata, input logic rerr,
                      output int acc, output logic [DW-1:0] rd, output logic er,
                      output int reqn, output int fbad);
    bit done, accepted, hs;
    int waitn;
    logic [AW-1:0] e_addr;
    logic [SW-1:0] e_strb;
    e_addr = addr - AW'(BASE);
    e_strb = wr ? strb : '1;
    @(negedge pclk);
    bus.psel = 1'b1; bus.penable = 1'b0; bus.paddr = addr; bus.pwrite = wr;
    bus.pwdata = wdata; bus.pstrb = strb; bus.pprot = prot;
    req_ready = 1'b0; rsp_valid = 1'b0;
    acc = 0; reqn = 0; fbad = 0; done = 0; accepted = 0; waitn = 0; rd = '0; er = 1'b0;
    while (!done && acc < 100) begin
      @(negedge pclk);
      bus.penable = 1'b1; acc++; req_ready = 1'b0; rsp_valid = 1'b0; hs = 0;
      if (bus.pready) begin
        done = 1; rd = bus.prdata; er = bus.pslverr;
      end else if (req_valid) begin
        reqn++;
        if (req_addr !== e_addr || req_write !== wr || req_prot !== prot ||
            req_strb !== e_strb || (wr && req_wdata !== wdata)) fbad++;
        if (reqn > rdly) begin req_ready = 1'b1; hs = 1; end
      end else if (accepted) begin
        waitn++;
        if (waitn == sdly + 1) begin
          rsp_valid = 1'b1; rsp_rdata = rdata; rsp_error = rerr;
        end
      end
      if (hs) accepted = 1;
    end
    if (!done) acc = -1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge pclk);
      bus.psel = 1'b0; bus.penable = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    presetn = 1'b0;
    bus.psel = 0; bus.penable = 0; bus.paddr = '0; bus.pwrite = 0;
    bus.pwdata = '0; bus.pstrb = '0; bus.pprot = '0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = '0; rsp_error = 0;
    repeat (3) @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    total++;
    if ({bus.pready, bus.pslverr, req_valid} !== 3'b000) begin
      bad++; $display("FAIL reset_ctrl: pready/pslverr/req_valid=%b want 000", {bus.pready, bus.pslverr, req_valid});
    end
    total++;
    if (bus.prdata !== '0 || req_addr !== '0 || req_wdata !== '0) begin
      bad++; $display("FAIL reset_data: prdata=%h req_addr=%h req_wdata=%h want 0", bus.prdata, req_addr, req_wdata);
    end
    total++;
    if ({req_write, req_prot, req_strb} !== '0) begin
      bad++; $display("FAIL reset_fields: write/prot/strb=%b want 0", {req_write, req_prot, req_strb});
    end
  endtask

  task automatic test_write_basic;
    int acc, reqn, fbad, e_acc, e_reqn; logic [DW-1:0] rd, e_rd; logic er, e_er;
    xfer(AW'(BASE + 'h10), 1'b1, 32'hDEADBEEF, 4'b0101, 3'b010, 0, 0, 32'h0, 1'b0, acc, rd, er, reqn, fbad);
    predict(AW'(BASE + 'h10), 1'b1, 4'b0101, 0, 0, 32'h0, 1'b0, e_acc, e_rd, e_er, e_reqn);
    total++;
    if (acc !== 3 || acc !== e_acc || er !== e_er) begin
      bad++; $display("FAIL write_basic: cycles=%0d err=%b want cycles=3 err=%b", acc, er, e_er);
    end
    total++;
    if (fbad !== 0 || reqn !== e_reqn || rd !== e_rd) begin
      bad++; $display("FAIL write_basic_req: fieldbad=%0d reqcyc=%0d prdata=%h want 0/%0d/%h", fbad, reqn, rd, e_reqn, e_rd);
    end
  endtask

  task automatic test_read_delayed;
    int acc, reqn, fbad, e_acc, e_reqn; logic [DW-1:0] rd, e_rd; logic er, e_er;
    xfer(AW'(BASE + 'h20), 1'b0, 32'hFFFF0000, 4'b0000, 3'b001, 4, 0, 32'h12345678, 1'b0, acc, rd, er, reqn, fbad);
    predict(AW'(BASE + 'h20), 1'b0, 4'b0000, 4, 0, 32'h12345678, 1'b0, e_acc, e_rd, e_er, e_reqn);
    total++;
    if (reqn !== 5 || reqn !== e_reqn || fbad !== 0) begin
      bad++; $display("FAIL read_delayed_req: reqcyc=%0d fieldbad=%0d want 5/0", reqn, fbad);
    end
    total++;
    if (rd !== e_rd || er !== e_er || acc !== e_acc) begin
      bad++; $display("FAIL read_delayed: prdata=%h err=%b cycles=%0d want %h/%b/%0d", rd, er, acc, e_rd, e_er, e_acc);
    end
    idle(1);
    total++;
    if (bus.prdata !== '0 || bus.pready !== 1'b0) begin
      bad++; $display("FAIL read_after: prdata=%h pready=%b want 0/0", bus.prdata, bus.pready);
    end
  endtask

  task automatic test_decode_errors;
    logic [AW-1:0] addrs [4];
    int acc, reqn, fbad, e_acc, e_reqn; logic [DW-1:0] rd, e_rd; logic er, e_er;
    addrs[0] = AW'(BASE + WIN); addrs[1] = AW'(BASE + 'h2);
    addrs[2] = AW'(BASE - 4);   addrs[3] = AW'(BASE + WIN - 1);
    for (int i = 0; i < 4; i++) begin
      xfer(addrs[i], i[0], 32'h55AA55AA, 4'hF, 3'b000, 0, 0, 32'hCAFEF00D, 1'b0, acc, rd, er, reqn, fbad);
      predict(addrs[i], i[0], 4'hF, 0, 0, 32'hCAFEF00D, 1'b0, e_acc, e_rd, e_er, e_reqn);
      total++;
      if (acc !== 1 || er !== 1'b1 || acc !== e_acc || er !== e_er || reqn !== 0 || rd !== '0) begin
        bad++; $display("FAIL decode_err[%0d]: cycles=%0d err=%b reqcyc=%0d prdata=%h want 1/1/0/0", i, acc, er, reqn, rd);
      end
    end
  endtask

  task automatic test_timeout;
    int rd_dly [2]; int rs_dly [2];
    int acc, reqn, fbad, e_acc, e_reqn; logic [DW-1:0] rd, e_rd; logic er, e_er;
    rd_dly[0] = 1000; rs_dly[0] = 0; rd_dly[1] = 0; rs_dly[1] = 1000;
    for (int i = 0; i < 2; i++) begin
      xfer(AW'(BASE + 'h40), 1'b0, 32'h0, 4'h0, 3'b100, rd_dly[i], rs_dly[i], 32'hBAD0BAD0, 1'b0, acc, rd, er, reqn, fbad);
      predict(AW'(BASE + 'h40), 1'b0, 4'h0, rd_dly[i], rs_dly[i], 32'hBAD0BAD0, 1'b0, e_acc, e_rd, e_er, e_reqn);
      total++;
      if (acc !== TO + 2 || acc !== e_acc || er !== 1'b1 || rd !== '0 || reqn !== e_reqn) begin
        bad++; $display("FAIL timeout[%0d]: cycles=%0d err=%b prdata=%h reqcyc=%0d want %0d/1/0/%0d", i, acc, er, rd, reqn, e_acc, e_reqn);
      end
      idle(2);
      @(negedge pclk);
      rsp_valid = 1'b1; rsp_rdata = 32'hDEAD0001; rsp_error = 1'b1;
      @(negedge pclk);
      rsp_valid = 1'b0;
      total++;
      if (bus.pready !== 1'b0 || bus.pslverr !== 1'b0 || req_valid !== 1'b0) begin
        bad++; $display("FAIL stray_rsp[%0d]: pready=%b pslverr=%b req_valid=%b want 0", i, bus.pready, bus.pslverr, req_valid);
      end
      xfer(AW'(BASE + 'h44), 1'b0, 32'h0, 4'h0, 3'b000, 1, 1, 32'h0BADCAFE, 1'b0, acc, rd, er, reqn, fbad);
      predict(AW'(BASE + 'h44), 1'b0, 4'h0, 1, 1, 32'h0BADCAFE, 1'b0, e_acc, e_rd, e_er, e_reqn);
      total++;
      if (acc !== e_acc || rd !== e_rd || er !== e_er || fbad !== 0) begin
        bad++; $display("FAIL after_timeout[%0d]: cycles=%0d prdata=%h err=%b want %0d/%h/%b", i, acc, rd, er, e_acc, e_rd, e_er);
      end
      idle(1);
    end
  endtask

  task automatic test_noop_and_rsp_error;
    int acc, reqn, fbad, e_acc, e_reqn; logic [DW-1:0] rd, e_rd; logic er, e_er;
    xfer(AW'(BASE + 'h80), 1'b1, 32'h11112222, 4'h0, 3'b000, 0, 0, 32'h0, 1'b0, acc, rd, er, reqn, fbad);
    total++;
    if (acc !== 1 || er !== 1'b0 || reqn !== 0) begin
      bad++; $display("FAIL noop_write: cycles=%0d err=%b reqcyc=%0d want 1/0/0", acc, er, reqn);
    end
    xfer(AW'(BASE + 'h84), 1'b0, 32'h0, 4'h0, 3'b011, 2, 2, 32'hA5A5C3C3, 1'b1, acc, rd, er, reqn, fbad);
    predict(AW'(BASE + 'h84), 1'b0, 4'h0, 2, 2, 32'hA5A5C3C3, 1'b1, e_acc, e_rd, e_er, e_reqn);
    total++;
    if (er !== 1'b1 || rd !== 32'hA5A5C3C3 || acc !== e_acc || fbad !== 0) begin
      bad++; $display("FAIL rsp_error: err=%b prdata=%h cycles=%0d want 1/a5a5c3c3/%0d", er, rd, acc, e_acc);
    end
    idle(1);
  endtask

  task automatic test_reset_mid;
    int acc, reqn, fbad, e_acc, e_reqn, n; logic [DW-1:0] rd, e_rd; logic er, e_er;
    @(negedge pclk);
    bus.psel = 1; bus.penable = 0; bus.paddr = AW'(BASE + 'h100); bus.pwrite = 0; bus.pprot = 3'b101;
    @(negedge pclk);
    bus.penable = 1; req_ready = 1;
    n = 0;
    while (req_valid !== 1'b1 && n < 10) begin @(negedge pclk); n++; end
    @(negedge pclk);
    req_ready = 0;
    #1 presetn = 1'b0;
    #1;
    total++;
    if ({bus.pready, bus.pslverr, req_valid, req_write, req_prot} !== '0 || bus.prdata !== '0 ||
        req_addr !== '0 || req_strb !== '0) begin
      bad++; $display("FAIL reset_mid: pready=%b req_valid=%b req_addr=%h req_strb=%b want all 0",
                      bus.pready, req_valid, req_addr, req_strb);
    end
    @(negedge pclk);
    presetn = 1'b1; bus.psel = 0; bus.penable = 0;
    rsp_valid = 1'b1; rsp_rdata = 32'hFEEDFACE; rsp_error = 1'b0;
    @(negedge pclk);
    rsp_valid = 1'b0;
    @(negedge pclk);
    total++;
    if (bus.pready !== 1'b0 || bus.prdata !== '0) begin
      bad++; $display("FAIL stale_rsp: pready=%b prdata=%h want 0/0", bus.pready, bus.prdata);
    end
    xfer(AW'(BASE + 'h104), 1'b0, 32'h0, 4'h0, 3'b000, 0, 3, 32'h600DF00D, 1'b0, acc, rd, er, reqn, fbad);
    predict(AW'(BASE + 'h104), 1'b0, 4'h0, 0, 3, 32'h600DF00D, 1'b0, e_acc, e_rd, e_er, e_reqn);
    total++;
    if (acc !== e_acc || rd !== e_rd || er !== e_er || fbad !== 0) begin
      bad++; $display("FAIL fresh_read: cycles=%0d prdata=%h err=%b want %0d/%h/%b", acc, rd, er, e_acc, e_rd, e_er);
    end
    idle(1);
  endtask

  task automatic test_random;
    int acc, reqn, fbad, e_acc, e_reqn, rdly, sdly, mode;
    logic [DW-1:0] rd, e_rd, wdata, rdata; logic er, e_er, wr, rerr;
    logic [AW-1:0] addr; logic [SW-1:0] strb; logic [2:0] prot;
    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 9);
      if (mode < 7)       addr = AW'(BASE + 4 * $urandom_range(0, WIN / 4 - 1));
      else if (mode == 7) addr = AW'(BASE + 4 * $urandom_range(0, WIN / 4 - 1) + $urandom_range(1, 3));
      else                addr = AW'($urandom);
      wr = 1'($urandom); wdata = $urandom; rdata = $urandom; rerr = ($urandom_range(0, 5) == 0);
      strb = SW'($urandom); prot = 3'($urandom);
      rdly = $urandom_range(0, 7); sdly = $urandom_range(0, 5);
      xfer(addr, wr, wdata, strb, prot, rdly, sdly, rdata, rerr, acc, rd, er, reqn, fbad);
      predict(addr, wr, strb, rdly, sdly, rdata, rerr, e_acc, e_rd, e_er, e_reqn);
      total++;
      if (acc !== e_acc || er !== e_er) begin
        bad++; $display("FAIL rand[%0d] timing: addr=%h wr=%b cycles=%0d err=%b want %0d/%b", i, addr, wr, acc, er, e_acc, e_er);
      end
      total++;
      if (rd !== e_rd) begin
        bad++; $display("FAIL rand[%0d] data: prdata=%h want %h", i, rd, e_rd);
      end
      total++;
      if (reqn !== e_reqn || fbad !== 0) begin
        bad++; $display("FAIL rand[%0d] req: reqcyc=%0d fieldbad=%0d want %0d/0", i, reqn, fbad, e_reqn);
      end
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
  endtask

  initial begin
    test_reset;
    test_write_basic;
    test_read_delayed;
    test_decode_errors;
    test_timeout;
    test_noop_and_rsp_error;
    test_reset_mid;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb4_completer_bridge.md
# apb4_completer_bridge

Parametrised APB4 completer that terminates an APB3/APB4 requester bus and forwards each in-window transfer to a generic backend over a valid/ready request channel and a valid-only response channel. It is the successor of the fixed 32-bit APB3 completer. It adds configurable data/address width, byte strobes, address-window and alignment checking, a backend response timeout, and registered error signalling. It sits between an APB interconnect and a co-simulation or memory backend.

## Interface
Parameters:
- AddressWidth, 20: width of paddr; 1..32.
- DataWidth, 32: width of pwdata/prdata; 8, 16, 32 or 64.
- BaseAddress, 0: first byte address of the decoded window; aligned to DataWidth/8.
- WindowSize, 'h1000: window size in bytes; power of two, at least DataWidth/8.
- TimeoutCycles, 256: backend timeout in cycles, counted from request issue; 0 disables the timeout.

Ports:
- pclk  in  1  clock; all logic on the rising edge.
- presetn  in  1  reset; asynchronous assert, active-low.
- paddr  in  AddressWidth  APB address.
- psel  in  1  select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write.
- pwdata  in  DataWidth  write data.
- pstrb  in  DataWidth/8  write byte strobes.
- pprot  in  3  protection; passed through to the backend.
- pready  out  1  transfer complete.
- prdata  out  DataWidth  read data.
- pslverr  out  1  error response.
- req_valid  out  1  backend request valid.
- req_ready  in  1  backend accepts the request.
- req_write, req_prot, req_addr, req_wdata, req_strb  out  1/3/AddressWidth/DataWidth/DataWidth/8  request fields; req_addr is the offset paddr - BaseAddress.
- rsp_valid  in  1  backend response (single-cycle pulse).
- rsp_rdata  in  DataWidth  response data.
- rsp_error  in  1  response error.

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - On a setup phase (psel=1, penable=0), capture paddr, pwrite, pwdata, pprot and pstrb.
  - Out-of-window or misaligned address (paddr[log2(DataWidth/8)-1:0] != 0): go to DONE with err=1, no backend request.
  - Write with pstrb=0: go to DONE with err=0, no backend request (no-op write).
  - Otherwise: go to REQ.
- REQ:
  - req_valid=1; request fields are held stable until acceptance.
  - On req_valid & req_ready: go to WAIT.
  - For reads, req_strb is forced all-ones regardless of pstrb.
- WAIT: on rsp_valid, capture rsp_rdata (reads only; writes capture 0) and rsp_error, then go to DONE.
- Response timing: rsp_valid is ignored in IDLE, REQ and DONE. Late or stray responses are discarded silently.
- Timeout:
  - The counter resets on entry to REQ and increments each cycle in REQ or WAIT.
  - When it reaches TimeoutCycles, go to DONE with err=1 and prdata=0. req_valid drops the same cycle; the request is abandoned.
  - A timeout and a rsp_valid/req_ready in the same cycle: the handshake wins.
- DONE:
  - pready=1, prdata=captured data (reads), pslverr=err, valid only while psel & penable.
  - Next state is IDLE when psel & penable; otherwise remain in DONE.
- prdata is 0 whenever pready=0 or the transfer is a write. pslverr is 0 whenever pready=0.
- Reset mid-transfer: all state returns to IDLE immediately. Any outstanding backend request is dropped, and a subsequent rsp_valid is discarded.

## Timing
- Reset values: pready=0, prdata=0, pslverr=0, req_valid=0, all req_* fields 0, state IDLE, timeout counter 0.
- pready, prdata, pslverr and req_valid are decoded from registered state only; there is no combinational path from APB inputs to these outputs.
- Setup phase at edge T0 → REQ at T1. req_ready=1 at T1 → WAIT at T2. rsp_valid at T2 → DONE at T3, pready=1 during T3. Minimum of 3 access-phase cycles for backend transfers.
- Error or no-op decode: DONE at T1, so pready=1 in the first access cycle (zero wait states).
- Timeout: err response is presented TimeoutCycles+1 cycles after REQ entry.
- Back-to-back: a new setup phase may follow in the cycle after pready; IDLE samples it on the next edge.

## Test plan
- Write at BaseAddress+'h10, pwdata='hDEADBEEF, pstrb='b0101, req_ready and rsp_valid immediate → req_addr='h10, req_strb='b0101; pready on the 3rd access cycle; pslverr=0.
- Read at 'h20 with req_ready delayed 4 cycles and rsp_rdata='h12345678 → req_valid held 5 cycles with stable fields; prdata='h12345678 only while pready=1; prdata=0 after.
- Read at BaseAddress+WindowSize, and a read at offset 'h2 (DataWidth=32) → pready=1, pslverr=1 in the first access cycle; req_valid never asserted.
- TimeoutCycles=8, backend never responds → pslverr=1, prdata=0 after 9 cycles. A rsp_valid injected 3 cycles later is ignored, and the next transfer completes normally.
- Write with pstrb=0 → zero-wait-state completion, pslverr=0, no req_valid. Then rsp_error=1 on a read → pslverr=1 with the captured rsp_rdata.
- Assert presetn low while in WAIT → all outputs 0 asynchronously. After release, the stale rsp_valid is discarded and a fresh read completes correctly.
